core_test_sequencer: RTL and testbench
======================================

Name: core_test_sequencer

Overview:
Synthesizable on-chip self-test controller for the lisp core: replays NUM_TESTS stored test records against the core. For each record it resets the core, loads a memory image through the core's memory write port, sets switches to the root expression and pulses start. It then waits for Halt or Error under a cycle timeout, waits a settle period, and checks val against the expected word. The block sits beside core on the FPGA top and replaces bench-only memory pokes; its result is driven to the LEDs.

Parameters:
WORD_W, 16, core word width (switches, val, memory data)
ADDR_W, 10, core memory address width
ROM_ADDR_W, 12, test-record ROM address width
NUM_TESTS, 4, number of records, 1..255
RST_CYCLES, 3, core reset assertion length in cycles, >=1
SETTLE_CYCLES, 3, cycles waited after Halt/Error before the check
TIMEOUT_CYCLES, 4096, maximum cycles from start pulse to Halt/Error

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
go  in  1  single-cycle pulse; starts a run when idle
rom_addr  out  ROM_ADDR_W  record ROM address
rom_data  in  WORD_W  ROM data, valid exactly 1 cycle after rom_addr
core_rst  out  1  active-high reset to core
core_switches  out  WORD_W  root expression pointer
core_btn_start  out  1  start pulse to core
mem_we  out  1  core memory write enable
mem_addr  out  ADDR_W  memory write address
mem_wdata  out  WORD_W  memory write data
core_halt  in  1  core in Halt state
core_error  in  1  core in Error state
core_val  in  WORD_W  core val register
busy  out  1  run in progress
done  out  1  run finished; held until next go
all_pass  out  1  valid when done
pass_count  out  8  records passed
fail_index  out  8  index of first failing record
fail_kind  out  2  0 none, 1 core Error, 2 val mismatch, 3 timeout
fail_val  out  WORD_W  core_val captured at the first failure

Behaviour:
- Reset values (rst low, asynchronous): state IDLE. All outputs 0, except core_rst=1 (core held in reset while idle) and fail_index=0.
- Record layout, contiguous from ROM address 0: expr, expected, N, then N pairs (addr, data). The next record follows the last pair. N=0 is legal: no writes.
- Only the low ADDR_W bits of each addr word are used.
- FSM:
  - IDLE: on go, clear pass_count/fail_*/done, set busy=1, record ptr=0, go to CORE_RST.
  - CORE_RST: core_rst=1 for RST_CYCLES cycles; header reads are issued in parallel.
  - HDR: 3 ROM reads; latch expr, expected, N; then core_rst=0.
  - LOAD: per pair, 2 ROM reads; mem_we=1 for exactly one cycle with the latched addr/data. Throughput is 1 write per 2 cycles minimum.
  - START: core_switches=expr (held through CHECK); core_btn_start=1 for exactly 1 cycle, then 1 idle cycle.
  - WAIT: counter increments per cycle. On core_halt or core_error go to SETTLE. If the counter reaches TIMEOUT_CYCLES, record a timeout.
  - SETTLE: SETTLE_CYCLES cycles.
  - CHECK:
    - error wins over halt, so core_error gives kind 1;
    - otherwise core_val != expected gives kind 2;
    - otherwise pass_count++.
  - NEXT: if more records remain go to CORE_RST, else DONE.
  - DONE: core_rst=1, busy=0, done=1; all_pass = (pass_count==NUM_TESTS). Return to IDLE on go.
- Failure handling:
  - Only the first failure latches fail_index/fail_kind/fail_val.
  - A failing record does not stop the run; the remaining records still execute.
  - On timeout, fail_val is core_val sampled at timeout.
- Halt and error asserted in the same cycle count as error.
- go while busy is ignored.
- rst asserted mid-run: immediate return to IDLE, core_rst=1, mem_we=0.
- mem_we is never asserted while core_rst=0 and the core is running (i.e. outside LOAD).

Test Plan:
- 1 record {expr=0x0001, expected=0x2A2A, N=2: (0x000,type_number word),(0x001,0x2A2A)}, core halts with val=0x2A2A -> done=1, all_pass=1, pass_count=1, fail_kind=0. Exactly 2 mem_we pulses at addr 0,1.
- Same record with expected=0x1234 -> all_pass=0, fail_kind=2, fail_index=0, fail_val=0x2A2A.
- 3 records; record 1 drives core_error; record 2 passes -> pass_count=2, fail_index=1, fail_kind=1; record 2 still executes (3 start pulses seen).
- TIMEOUT_CYCLES=16, core never halts -> fail_kind=3 exactly 16 cycles after the start pulse; done=1.
- N=0 record -> no mem_we; start pulse occurs 1 cycle after the header is latched.
- rst low during LOAD -> outputs return to reset values immediately. A second go then reruns from record 0 and passes.

Source files
------------

// File: rtl/core_test_sequencer.sv
// Self-test controller: replays NUM_TESTS ROM test records against the lisp core and reports pass/fail.
// Latency: per record RST_CYCLES+1 header cycles, 2 cycles per memory write, core run time (<=TIMEOUT_CYCLES), SETTLE_CYCLES+2.
// Backpressure: none; ROM has a fixed 1-cycle read latency and go is ignored while a run is in progress.
module core_test_sequencer #(
    parameter int WORD_W         = 16,
    parameter int ADDR_W         = 10,
    parameter int ROM_ADDR_W     = 12,
    parameter int NUM_TESTS      = 4,
    parameter int RST_CYCLES     = 3,
    parameter int SETTLE_CYCLES  = 3,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    input  logic [WORD_W-1:0]     rom_data,
    output logic                  core_rst,
    output logic [WORD_W-1:0]     core_switches,
    output logic                  core_btn_start,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [WORD_W-1:0]     mem_wdata,
    input  logic                  core_halt,
    input  logic                  core_error,
    input  logic [WORD_W-1:0]     core_val,
    output logic                  busy,
    output logic                  done,
    output logic                  all_pass,
    output logic [7:0]            pass_count,
    output logic [7:0]            fail_index,
    output logic [1:0]            fail_kind,
    output logic [WORD_W-1:0]     fail_val
);
    // RST_CYCLES and SETTLE_CYCLES are assumed >= 1, TIMEOUT_CYCLES >= 3.
    localparam int CNT_W = 16;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMO_LAST    = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       LAST_REC    = 8'(NUM_TESTS - 1);
    localparam logic [7:0]       NUM_REC     = 8'(NUM_TESTS);

    // Tag travelling with each ROM read so the returning word lands in the right place.
    localparam logic [2:0] TAG_EXPR = 3'd0, TAG_EXP = 3'd1, TAG_N = 3'd2, TAG_ADDR = 3'd3, TAG_DATA = 3'd4;
    localparam logic [1:0] KIND_NONE = 2'd0, KIND_ERROR = 2'd1, KIND_VAL = 2'd2, KIND_TMO = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE, S_CORE_RST, S_HDR, S_LOAD, S_START, S_GAP, S_WAIT, S_SETTLE, S_CHECK, S_NEXT, S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ROM_ADDR_W-1:0]   ptr_q, ptr_d;
    logic                    rd_vld_q, rd_vld_d;
    logic [2:0]              rd_tag_q, rd_tag_d;
    logic [1:0]              hdr_iss_q, hdr_iss_d;
    logic [1:0]              hdr_got_q, hdr_got_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [TMR_W-1:0]        tmr_q, tmr_d;
    logic [WORD_W-1:0]       expr_q, expr_d;
    logic [WORD_W-1:0]       exp_q, exp_d;
    logic [WORD_W-1:0]       n_q, n_d;
    logic [WORD_W:0]         pair_iss_q, pair_iss_d;
    logic [WORD_W-1:0]       wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0]       waddr_q, waddr_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]       mem_wdata_q, mem_wdata_d;
    logic [7:0]              rec_q, rec_d;
    logic [7:0]              pass_q, pass_d;
    logic [7:0]              fidx_q, fidx_d;
    logic [1:0]              fkind_q, fkind_d;
    logic [WORD_W-1:0]       fval_q, fval_d;
    logic                    fail_now;
    logic [1:0]              fail_kind_now;

    // Next-state logic: ROM return capture, read issue, and the per-record sequencing FSM.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        rd_vld_d      = 1'b0;
        rd_tag_d      = rd_tag_q;
        hdr_iss_d     = hdr_iss_q;
        hdr_got_d     = hdr_got_q;
        cnt_d         = cnt_q;
        tmr_d         = tmr_q;
        expr_d        = expr_q;
        exp_d         = exp_q;
        n_d           = n_q;
        pair_iss_d    = pair_iss_q;
        wr_cnt_d      = wr_cnt_q;
        waddr_d       = waddr_q;
        mem_we_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        rec_d         = rec_q;
        pass_d        = pass_q;
        fidx_d        = fidx_q;
        fkind_d       = fkind_q;
        fval_d        = fval_q;
        fail_now      = 1'b0;
        fail_kind_now = KIND_NONE;

        // Word requested last cycle is on rom_data now.
        if (rd_vld_q) begin
            case (rd_tag_q)
                TAG_EXPR: begin expr_d = rom_data; hdr_got_d = hdr_got_q + 2'd1; end
                TAG_EXP:  begin exp_d  = rom_data; hdr_got_d = hdr_got_q + 2'd1; end
                TAG_N:    begin n_d    = rom_data; hdr_got_d = hdr_got_q + 2'd1; end
                TAG_ADDR: waddr_d = rom_data[ADDR_W-1:0];
                TAG_DATA: begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = waddr_q;
                    mem_wdata_d = rom_data;
                end
                default: ;
            endcase
        end

        // Header reads overlap the core reset window.
        if ((state_q == S_CORE_RST || state_q == S_HDR) && hdr_iss_q != 2'd3) begin
            rd_vld_d  = 1'b1;
            rd_tag_d  = {1'b0, hdr_iss_q};
            ptr_d     = ptr_q + ROM_ADDR_W'(1);
            hdr_iss_d = hdr_iss_q + 2'd1;
        end
        // Pair reads stream back to back; every second return produces one write.
        if (state_q == S_LOAD && pair_iss_q < {n_q, 1'b0}) begin
            rd_vld_d   = 1'b1;
            rd_tag_d   = pair_iss_q[0] ? TAG_DATA : TAG_ADDR;
            ptr_d      = ptr_q + ROM_ADDR_W'(1);
            pair_iss_d = pair_iss_q + (WORD_W+1)'(1);
        end
        if (mem_we_q) begin
            wr_cnt_d = wr_cnt_q + WORD_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    pass_d  = '0;
                    fidx_d  = '0;
                    fkind_d = KIND_NONE;
                    fval_d  = '0;
                    rec_d   = '0;
                    ptr_d   = '0;
                    state_d = S_CORE_RST;
                end
            end
            S_CORE_RST: begin
                if (cnt_q == RST_LAST) state_d = S_HDR;
                else                   cnt_d   = cnt_q + CNT_W'(1);
            end
            S_HDR: begin
                // N may already be latched if the reset window covered all header reads.
                if (hdr_got_q == 2'd3)
                    state_d = (n_q == '0) ? S_START : S_LOAD;
                else if (rd_vld_q && rd_tag_q == TAG_N)
                    state_d = (rom_data == '0) ? S_START : S_LOAD;
            end
            S_LOAD: begin
                if (mem_we_q && (wr_cnt_q + WORD_W'(1)) == n_q) state_d = S_START;
            end
            S_START: begin
                tmr_d   = TMR_W'(1);
                state_d = S_GAP;
            end
            S_GAP: begin
                tmr_d   = tmr_q + TMR_W'(1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // tmr_q counts cycles since the start pulse.
                if (core_halt || core_error) begin
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end else if (tmr_q == TMO_LAST) begin
                    fail_now      = 1'b1;
                    fail_kind_now = KIND_TMO;
                    state_d       = S_NEXT;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) state_d = S_CHECK;
                else                      cnt_d   = cnt_q + CNT_W'(1);
            end
            S_CHECK: begin
                if (core_error) begin
                    fail_now      = 1'b1;
                    fail_kind_now = KIND_ERROR;
                end else if (core_val != exp_q) begin
                    fail_now      = 1'b1;
                    fail_kind_now = KIND_VAL;
                end else begin
                    pass_d = pass_q + 8'd1;
                end
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if (rec_q == LAST_REC) begin
                    state_d = S_DONE;
                end else begin
                    rec_d   = rec_q + 8'd1;
                    state_d = S_CORE_RST;
                end
            end
            S_DONE: begin
                if (go) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Only the first failing record of a run is reported.
        if (fail_now && fkind_q == KIND_NONE) begin
            fkind_d = fail_kind_now;
            fidx_d  = rec_q;
            fval_d  = core_val;
        end

        // Fresh per-record bookkeeping whenever a record's reset window begins.
        if (state_d == S_CORE_RST && state_q != S_CORE_RST) begin
            hdr_iss_d  = '0;
            hdr_got_d  = '0;
            cnt_d      = '0;
            pair_iss_d = '0;
            wr_cnt_d   = '0;
        end
    end

    // State and datapath registers; reset parks the core in reset with no writes pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            rd_vld_q    <= 1'b0;
            rd_tag_q    <= '0;
            hdr_iss_q   <= '0;
            hdr_got_q   <= '0;
            cnt_q       <= '0;
            tmr_q       <= '0;
            expr_q      <= '0;
            exp_q       <= '0;
            n_q         <= '0;
            pair_iss_q  <= '0;
            wr_cnt_q    <= '0;
            waddr_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rec_q       <= '0;
            pass_q      <= '0;
            fidx_q      <= '0;
            fkind_q     <= KIND_NONE;
            fval_q      <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rd_vld_q    <= rd_vld_d;
            rd_tag_q    <= rd_tag_d;
            hdr_iss_q   <= hdr_iss_d;
            hdr_got_q   <= hdr_got_d;
            cnt_q       <= cnt_d;
            tmr_q       <= tmr_d;
            expr_q      <= expr_d;
            exp_q       <= exp_d;
            n_q         <= n_d;
            pair_iss_q  <= pair_iss_d;
            wr_cnt_q    <= wr_cnt_d;
            waddr_q     <= waddr_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rec_q       <= rec_d;
            pass_q      <= pass_d;
            fidx_q      <= fidx_d;
            fkind_q     <= fkind_d;
            fval_q      <= fval_d;
        end
    end

    // Outputs decoded from state; the core is held in reset except while loading and running.
    always_comb begin
        rom_addr       = ptr_q;
        core_rst       = (state_q == S_IDLE) || (state_q == S_CORE_RST) ||
                         (state_q == S_HDR)  || (state_q == S_DONE);
        core_btn_start = (state_q == S_START);
        core_switches  = ((state_q == S_START) || (state_q == S_GAP) || (state_q == S_WAIT) ||
                          (state_q == S_SETTLE) || (state_q == S_CHECK)) ? expr_q : '0;
        mem_we         = mem_we_q;
        mem_addr       = mem_addr_q;
        mem_wdata      = mem_wdata_q;
        busy           = (state_q != S_IDLE) && (state_q != S_DONE);
        done           = (state_q == S_DONE);
        all_pass       = (state_q == S_DONE) && (pass_q == NUM_REC);
        pass_count     = pass_q;
        fail_index     = fidx_q;
        fail_kind      = fkind_q;
        fail_val       = fval_q;
    end
endmodule

// File: tb/tb_core_test_sequencer.sv
// Bench for core_test_sequencer: random and directed ROM record sets against a behavioural core model.
// Latency: expected writes, start pulses and run results are queued at stimulus time and popped by a monitor.
// Backpressure: none; the monitor samples DUT outputs on the falling clock edge.
`timescale 1ns/1ps
module tb_core_test_sequencer;
    localparam int WORD_W = 16;
    localparam int ADDR_W = 10;
    localparam int ROM_W  = 12;
    localparam int NT     = 3;
    localparam int TMO    = 16;
    localparam logic [15:0] TYPE_NUMBER_WORD = 16'h1000;

    typedef struct packed { logic [ADDR_W-1:0] a; logic [15:0] d; } wr_t;
    typedef struct packed { logic [15:0] expr; logic nz; } st_t;
    typedef struct packed { logic [7:0] pc; logic [7:0] fi; logic [1:0] fk; logic [15:0] fv; logic ap; } res_t;
    // kind: 0 halt, 1 error, 2 halt+error, 3 never finishes
    typedef struct packed { logic [1:0] kind; logic [3:0] lat; logic [15:0] v0; logic [15:0] v1; } beh_t;

    logic clk = 1'b0;
    logic rst, go;
    logic [ROM_W-1:0]  rom_addr;
    logic [WORD_W-1:0] rom_data;
    logic core_rst, core_btn_start, mem_we, core_halt, core_error;
    logic [WORD_W-1:0] core_switches, mem_wdata, core_val, fail_val;
    logic [ADDR_W-1:0] mem_addr;
    logic busy, done, all_pass;
    logic [7:0] pass_count, fail_index;
    logic [1:0] fail_kind;

    core_test_sequencer #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .ROM_ADDR_W(ROM_W), .NUM_TESTS(NT),
                          .RST_CYCLES(3), .SETTLE_CYCLES(3), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .go(go), .rom_addr(rom_addr), .rom_data(rom_data),
        .core_rst(core_rst), .core_switches(core_switches), .core_btn_start(core_btn_start),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_halt(core_halt), .core_error(core_error), .core_val(core_val),
        .busy(busy), .done(done), .all_pass(all_pass), .pass_count(pass_count),
        .fail_index(fail_index), .fail_kind(fail_kind), .fail_val(fail_val));

    always #5 clk = ~clk;

    logic [15:0] rom [0:(1<<ROM_W)-1];
    always @(posedge clk) rom_data <= rom[rom_addr];

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name, input string what);
        n_checks++;
        n_errs++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Record set for the next run
    logic [15:0] r_expr [NT];
    logic [15:0] r_exp  [NT];
    int          r_n    [NT];
    logic [15:0] r_a    [NT][4];
    logic [15:0] r_d    [NT][4];
    beh_t        r_b    [NT];

    wr_t  wr_q  [$];
    st_t  st_q  [$];
    res_t res_q [$];
    beh_t beh_q [$];

    task automatic set_rand_rec(input int i);
        int pick;
        r_expr[i] = 16'($urandom);
        r_exp[i]  = 16'($urandom);
        r_n[i]    = $urandom_range(0, 4);
        for (int j = 0; j < 4; j++) begin
            r_a[i][j] = 16'($urandom);
            r_d[i][j] = 16'($urandom);
        end
        pick = $urandom_range(0, 9);
        r_b[i].lat = 4'($urandom_range(1, 12));
        r_b[i].v0  = 16'($urandom);
        r_b[i].v1  = r_exp[i];
        case (pick)
            5:       begin r_b[i].kind = 2'd0; r_b[i].v1 = r_exp[i] + 16'd1; end
            6:       r_b[i].kind = 2'd1;
            7:       r_b[i].kind = 2'd2;
            8:       r_b[i].kind = 2'd3;
            default: r_b[i].kind = 2'd0;
        endcase
    endtask

    task automatic set_pass_rec(input int i);
        set_rand_rec(i);
        r_b[i].kind = 2'd0;
        r_b[i].v1   = r_exp[i];
    endtask

    task automatic set_plan_rec(input int i, input logic [15:0] expected);
        set_pass_rec(i);
        r_expr[i] = 16'h0001;
        r_exp[i]  = expected;
        r_n[i]    = 2;
        r_a[i][0] = 16'h0000; r_d[i][0] = TYPE_NUMBER_WORD;
        r_a[i][1] = 16'h0001; r_d[i][1] = 16'h2A2A;
        r_b[i].v1 = 16'h2A2A;
    endtask

    // Lay the records out in ROM and queue every response the run should produce.
    task automatic build_and_push();
        int p;
        int k;
        wr_t w;
        st_t s;
        res_t r;
        logic [15:0] v;
        p = 0;
        r.pc = 0; r.fi = 0; r.fk = 0; r.fv = 0;
        for (int i = 0; i < NT; i++) begin
            rom[p] = r_expr[i]; rom[p+1] = r_exp[i]; rom[p+2] = 16'(r_n[i]);
            p += 3;
            for (int j = 0; j < r_n[i]; j++) begin
                rom[p] = r_a[i][j]; rom[p+1] = r_d[i][j];
                p += 2;
                w.a = r_a[i][j][ADDR_W-1:0];
                w.d = r_d[i][j];
                wr_q.push_back(w);
            end
            s.expr = r_expr[i];
            s.nz   = (r_n[i] == 0);
            st_q.push_back(s);
            beh_q.push_back(r_b[i]);
            case (r_b[i].kind)
                2'd0:       begin k = (r_b[i].v1 == r_exp[i]) ? 0 : 2; v = r_b[i].v1; end
                2'd1, 2'd2: begin k = 1; v = r_b[i].v1; end
                default:    begin k = 3; v = r_b[i].v0; end
            endcase
            if (k == 0) r.pc = r.pc + 8'd1;
            else if (r.fk == 2'd0) begin r.fk = 2'(k); r.fi = 8'(i); r.fv = v; end
        end
        r.ap = (r.pc == 8'(NT));
        res_q.push_back(r);
    endtask

    task automatic pulse_go();
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
    endtask

    task automatic launch();
        if (done) pulse_go();
        pulse_go();
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (!done && k < 3000) begin @(negedge clk); k++; end
        check({name, "_done"}, 32'(done), 1);
        repeat (2) @(negedge clk);
        check({name, "_writes_left"}, wr_q.size(), 0);
        check({name, "_starts_left"}, st_q.size(), 0);
        check({name, "_results_left"}, res_q.size(), 0);
    endtask

    // Behavioural core: runs the queued behaviour after each start pulse, cleared by core_rst.
    beh_t cur;
    int   cdown;
    initial begin
        core_halt = 1'b0; core_error = 1'b0; core_val = '0; cdown = 0;
        forever begin
            @(negedge clk);
            if (core_rst) begin
                core_halt = 1'b0; core_error = 1'b0; core_val = '0; cdown = 0;
            end else if (core_btn_start) begin
                if (beh_q.size() != 0) begin
                    cur = beh_q.pop_front();
                    core_val = cur.v0;
                    cdown = (cur.kind == 2'd3) ? 0 : int'(cur.lat);
                end
            end else if (cdown > 0) begin
                cdown--;
                if (cdown == 0) begin
                    core_val   = cur.v1;
                    core_halt  = (cur.kind != 2'd1);
                    core_error = (cur.kind != 2'd0);
                end
            end
        end
    end

    // Monitor: pops and compares whenever the DUT presents a write, start pulse, or finished run.
    int         cyc = 0;
    int         last_start = 0;
    logic       prev_done = 1'b0;
    logic       prev_crst = 1'b1;
    logic [1:0] prev_kind = 2'd0;
    initial begin
        wr_t w; st_t s; res_t r;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                if (mem_we) begin
                    if (wr_q.size() == 0) fail_event("extra_write", $sformatf("addr 0x%0h with nothing queued", mem_addr));
                    else begin
                        w = wr_q.pop_front();
                        check("write_addr", 32'(mem_addr), 32'(w.a));
                        check("write_data", 32'(mem_wdata), 32'(w.d));
                        check("write_core_rst", 32'(core_rst), 0);
                    end
                end
                if (core_btn_start) begin
                    last_start = cyc;
                    if (st_q.size() == 0) fail_event("extra_start", "start pulse with nothing queued");
                    else begin
                        s = st_q.pop_front();
                        check("start_switches", 32'(core_switches), 32'(s.expr));
                        check("start_core_rst", 32'(core_rst), 0);
                        if (s.nz) check("n0_start_after_header", 32'(prev_crst), 1);
                    end
                end
                if (fail_kind == 2'd3 && prev_kind != 2'd3)
                    check("timeout_latency", 32'(cyc - last_start), TMO);
                if (done && !prev_done) begin
                    if (res_q.size() == 0) fail_event("extra_done", "done with nothing queued");
                    else begin
                        r = res_q.pop_front();
                        check("pass_count", 32'(pass_count), 32'(r.pc));
                        check("fail_index", 32'(fail_index), 32'(r.fi));
                        check("fail_kind", 32'(fail_kind), 32'(r.fk));
                        check("fail_val", 32'(fail_val), 32'(r.fv));
                        check("all_pass", 32'(all_pass), 32'(r.ap));
                        check("busy_at_done", 32'(busy), 0);
                    end
                end
                prev_done = done;
                prev_crst = core_rst;
                prev_kind = fail_kind;
            end else begin
                prev_done = 1'b0;
                prev_crst = 1'b1;
                prev_kind = 2'd0;
            end
        end
    end

    task automatic check_reset_values(input string name);
        check({name, "_core_rst"}, 32'(core_rst), 1);
        check({name, "_mem_we"}, 32'(mem_we), 0);
        check({name, "_busy"}, 32'(busy), 0);
        check({name, "_done"}, 32'(done), 0);
        check({name, "_btn"}, 32'(core_btn_start), 0);
        check({name, "_pass_count"}, 32'(pass_count), 0);
        check({name, "_fail_kind"}, 32'(fail_kind), 0);
        check({name, "_fail_index"}, 32'(fail_index), 0);
        check({name, "_rom_addr"}, 32'(rom_addr), 0);
        check({name, "_switches"}, 32'(core_switches), 0);
    endtask

    initial begin
        int k;
        rst = 1'b0;
        go  = 1'b0;
        for (int i = 0; i < (1 << ROM_W); i++) rom[i] = '0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Plan record passes, N=0 record, and a third passing record
        set_plan_rec(0, 16'h2A2A);
        set_pass_rec(1); r_n[1] = 0;
        set_pass_rec(2); r_n[2] = 3;
        build_and_push(); launch(); wait_done("all_pass");

        // Plan record with wrong expected value
        set_plan_rec(0, 16'h1234);
        set_pass_rec(1); set_pass_rec(2);
        build_and_push(); launch(); wait_done("mismatch");

        // Error on record 1, record 2 still runs; a go while busy must be ignored
        set_pass_rec(0); set_pass_rec(1); set_pass_rec(2);
        r_b[1].kind = 2'd1; r_b[1].v1 = 16'hBEEF;
        build_and_push(); launch();
        repeat (10) @(negedge clk);
        pulse_go();
        wait_done("error");

        // Core never finishes on record 0
        set_pass_rec(0); set_pass_rec(1); set_pass_rec(2);
        r_b[0].kind = 2'd3;
        build_and_push(); launch(); wait_done("timeout");

        // Reset in the middle of LOAD, then a clean rerun from record 0
        set_pass_rec(0); r_n[0] = 4;
        set_pass_rec(1); set_pass_rec(2);
        build_and_push(); launch();
        k = 0;
        while (!mem_we && k < 200) begin @(negedge clk); k++; end
        check("midrun_saw_write", 32'(mem_we), 1);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check_reset_values("midrun_rst");
        wr_q.delete(); st_q.delete(); res_q.delete(); beh_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        build_and_push(); launch(); wait_done("rerun");

        // Random record sets
        for (int run = 0; run < 8; run++) begin
            for (int i = 0; i < NT; i++) set_rand_rec(i);
            build_and_push(); launch(); wait_done("random");
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
